// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// width defaults and the starvation counter width helper.
package dm_arbiter_pkg;

    localparam int ADDR_W_DEF   = 4;
    localparam int DATA_W_DEF   = 4;
    localparam int MAX_WAIT_DEF = 4;

    // Encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    // Bits needed to count 0..max_wait inclusive.
    function automatic int cnt_width(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// CPU, host and data-memory signals seen by the arbiter.
// slave: the arbiter side. master: the CPU/host/memory environment side.
interface dm_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  host_req, host_we, host_addr, host_wdata,
        output host_rdata, host_ack,
        output mem_addr, mem_wdata, mem_wren,
        input  mem_q
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output host_req, host_we, host_addr, host_wdata,
        input  host_rdata, host_ack,
        input  mem_addr, mem_wdata, mem_wren,
        output mem_q
    );
endinterface

// File: rtl/dm_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; tracks how long the host
// has been losing to the CPU.
module sat_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] cnt
);

    // Clear wins over increment; stop counting once max is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != max)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the 16x4 data memory between the CPU port and a req/ack host port.
// The CPU wins by default; after MAX_WAIT lost cycles the host is forced in.
// The memory itself is clocked on the falling edge, outside this block.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    dm_arbiter_if.slave bus
);

    localparam int             CNT_W   = cnt_width(MAX_WAIT);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    arb_state_t        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              host_ack_q;
    logic [DATA_W-1:0] host_rdata_q;
    logic              grant;
    logic              cnt_inc;
    logic              cnt_clr;
    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_wdata;
    logic              mux_wren;

    // Grant decision is only taken in IDLE; a host losing to the CPU ages.
    always_comb begin
        grant   = (state == IDLE) && bus.host_req &&
                  (!bus.cpu_req || (wait_cnt == MAX_CNT));
        cnt_inc = (state == IDLE) && bus.host_req && bus.cpu_req && !grant;
        cnt_clr = grant || ((state == IDLE) && !bus.host_req);
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .max   (MAX_CNT),
        .cnt   (wait_cnt)
    );

    // Host FSM: one grant cycle, one ack cycle, then back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    host_ack_q <= 1'b0;
                    if (grant) begin
                        state <= GNT;
                    end
                end
                GNT: begin
                    state      <= ACK;
                    host_ack_q <= 1'b1;
                    if (!bus.host_we) begin
                        host_rdata_q <= bus.mem_q;
                    end
                end
                ACK: begin
                    state      <= IDLE;
                    host_ack_q <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    host_ack_q <= 1'b0;
                end
            endcase
        end
    end

    // Memory port goes to the host only during GNT, so there is one writer.
    always_comb begin
        if (state == GNT) begin
            mux_addr  = bus.host_addr;
            mux_wdata = bus.host_wdata;
            mux_wren  = bus.host_we;
        end else begin
            mux_addr  = bus.cpu_addr;
            mux_wdata = bus.cpu_wdata;
            mux_wren  = bus.cpu_req && bus.cpu_we;
        end
    end

    assign bus.mem_addr   = mux_addr;
    assign bus.mem_wdata  = mux_wdata;
    assign bus.mem_wren   = mux_wren;
    assign bus.cpu_rdata  = bus.mem_q;
    assign bus.cpu_stall  = bus.cpu_req && (state == GNT);
    assign bus.host_rdata = host_rdata_q;
    assign bus.host_ack   = host_ack_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a falling-edge data memory model, a table of CPU
// mux vectors, a table of host transactions checked through a scoreboard
// queue, and hand sequences for starvation, held request, no-forwarding
// and reset during a grant.
`timescale 1ns/1ps
module tb_dm_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic mem_init;
    logic [3:0] mem [16];

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic       req;
        logic       we;
        logic [3:0] addr;
        logic [3:0] wdata;
        logic       wren;
        logic [3:0] rd;
    } mux_vec_t;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [3:0] wdata;
        logic [3:0] exp_rdata;
    } host_vec_t;

    typedef struct {
        logic       is_read;
        logic [3:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];

    dm_arbiter_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    dm_arbiter #(
        .ADDR_W   (4),
        .DATA_W   (4),
        .MAX_WAIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Data memory: written on the falling edge, read asynchronously.
    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'(i) ^ 4'hF;
        end else if (bus.mem_wren) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_q = mem[bus.mem_addr];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        #2;
    endtask

    task automatic host_op(input logic we, input logic [3:0] addr,
                           input logic [3:0] wdata, input logic [3:0] exp);
        int lat;
        bit got;
        sb_entry_t e;
        step();
        bus.host_req   = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = addr;
        bus.host_wdata = wdata;
        sb.push_back('{is_read: !we, exp: exp});
        got = 1'b0;
        lat = -1;
        for (int n = 0; n < 8; n++) begin
            step();
            sample();
            if (bus.host_ack) begin
                got = 1'b1;
                lat = n;
                break;
            end
        end
        bus.host_req = 1'b0;
        chk("host_ack_seen", 8'(got), 8'd1);
        e = sb.pop_front();
        if (got) begin
            chk("host_grant_to_ack", 8'(lat), 8'd1);
            if (e.is_read) chk("host_rdata", 8'(bus.host_rdata), 8'(e.exp));
        end
    endtask

    mux_vec_t  mvec [6];
    host_vec_t hvec [8];
    logic      ack_pat  [6];
    logic [3:0] addr_pat [6];

    initial begin
        mvec[0] = '{1'b1, 1'b1, 4'h8, 4'h5, 1'b1, 4'h7};
        mvec[1] = '{1'b1, 1'b0, 4'h8, 4'h0, 1'b0, 4'h5};
        mvec[2] = '{1'b0, 1'b1, 4'h9, 4'h3, 1'b0, 4'h6};
        mvec[3] = '{1'b1, 1'b0, 4'h9, 4'h2, 1'b0, 4'h6};
        mvec[4] = '{1'b1, 1'b1, 4'h9, 4'h4, 1'b1, 4'h6};
        mvec[5] = '{1'b0, 1'b0, 4'h9, 4'h0, 1'b0, 4'h4};

        hvec[0] = '{1'b0, 4'h3, 4'h0, 4'hA};
        hvec[1] = '{1'b1, 4'h5, 4'h6, 4'h0};
        hvec[2] = '{1'b0, 4'h5, 4'h0, 4'h6};
        hvec[3] = '{1'b1, 4'h2, 4'h1, 4'h0};
        hvec[4] = '{1'b0, 4'h2, 4'h0, 4'h1};
        hvec[5] = '{1'b0, 4'h0, 4'h0, 4'hF};
        hvec[6] = '{1'b1, 4'h3, 4'hC, 4'h0};
        hvec[7] = '{1'b0, 4'h3, 4'h0, 4'hC};

        ack_pat  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        addr_pat = '{4'h3, 4'h0, 4'h0, 4'h3, 4'h0, 4'h0};

        // Reset state
        reset          = 1'b1;
        mem_init       = 1'b1;
        bus.cpu_req    = 1'b1;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = 4'h0;
        bus.cpu_wdata  = 4'h0;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = 4'h0;
        bus.host_wdata = 4'h0;
        step();
        step();
        sample();
        chk("reset_host_ack", 8'(bus.host_ack), 8'd0);
        chk("reset_host_rdata", 8'(bus.host_rdata), 8'd0);
        chk("reset_cpu_stall", 8'(bus.cpu_stall), 8'd0);
        mem_init    = 1'b0;
        reset       = 1'b0;
        bus.cpu_req = 1'b0;

        // CPU-only memory mux vectors
        for (int i = 0; i < 6; i++) begin
            step();
            bus.cpu_req   = mvec[i].req;
            bus.cpu_we    = mvec[i].we;
            bus.cpu_addr  = mvec[i].addr;
            bus.cpu_wdata = mvec[i].wdata;
            sample();
            chk("mux_addr", 8'(bus.mem_addr), 8'(mvec[i].addr));
            chk("mux_wdata", 8'(bus.mem_wdata), 8'(mvec[i].wdata));
            chk("mux_wren", 8'(bus.mem_wren), 8'(mvec[i].wren));
            chk("mux_stall", 8'(bus.cpu_stall), 8'd0);
            chk("mux_cpu_rdata", 8'(bus.cpu_rdata), 8'(mvec[i].rd));
        end
        bus.cpu_req  = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 4'h0;

        // Idle host write: immediate grant, write in the grant cycle
        step();
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 4'h3;
        bus.host_wdata = 4'hA;
        step();
        sample();
        chk("idle_wr_gnt_wren", 8'(bus.mem_wren), 8'd1);
        chk("idle_wr_gnt_addr", 8'(bus.mem_addr), 8'h3);
        chk("idle_wr_gnt_wdata", 8'(bus.mem_wdata), 8'hA);
        chk("idle_wr_gnt_ack", 8'(bus.host_ack), 8'd0);
        step();
        sample();
        chk("idle_wr_ack", 8'(bus.host_ack), 8'd1);
        bus.host_req = 1'b0;

        // Host transaction table through the scoreboard
        for (int i = 0; i < 8; i++) begin
            host_op(hvec[i].we, hvec[i].addr, hvec[i].wdata, hvec[i].exp_rdata);
        end

        // CPU priority then starvation-forced grant
        step();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 4'h5;
        bus.cpu_wdata = 4'h7;
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 4'h7;
        sample();
        chk("prio_wren", 8'(bus.mem_wren), 8'd1);
        chk("prio_addr", 8'(bus.mem_addr), 8'h5);
        chk("prio_wdata", 8'(bus.mem_wdata), 8'h7);
        chk("prio_stall", 8'(bus.cpu_stall), 8'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) begin
                bus.cpu_we   = 1'b0;
                bus.cpu_addr = 4'h1;
            end
            sample();
            chk("starve_stall_low", 8'(bus.cpu_stall), 8'd0);
            chk("starve_ack_low", 8'(bus.host_ack), 8'd0);
            chk("starve_cpu_owns_mem", 8'(bus.mem_addr), 8'h1);
        end
        step();
        sample();
        chk("starve_gnt_stall", 8'(bus.cpu_stall), 8'd1);
        chk("starve_gnt_addr", 8'(bus.mem_addr), 8'h7);
        chk("starve_gnt_ack", 8'(bus.host_ack), 8'd0);
        step();
        sample();
        chk("starve_ack", 8'(bus.host_ack), 8'd1);
        chk("starve_ack_stall", 8'(bus.cpu_stall), 8'd0);
        chk("starve_rdata", 8'(bus.host_rdata), 8'h8);
        bus.host_req = 1'b0;
        bus.cpu_addr = 4'h5;
        #1;
        chk("prio_write_landed", 8'(bus.cpu_rdata), 8'h7);

        // Host request held through ACK
        step();
        bus.cpu_req   = 1'b0;
        bus.cpu_addr  = 4'h0;
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 4'h3;
        for (int i = 0; i < 6; i++) begin
            step();
            sample();
            chk("held_ack", 8'(bus.host_ack), 8'(ack_pat[i]));
            chk("held_mem_addr", 8'(bus.mem_addr), 8'(addr_pat[i]));
            if (ack_pat[i]) chk("held_rdata", 8'(bus.host_rdata), 8'hC);
            if (i == 4) bus.host_req = 1'b0;
        end

        // No forwarding of a CPU write in the host ACK cycle
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 4'h2;
        step();
        sample();
        chk("nofwd_gnt_addr", 8'(bus.mem_addr), 8'h2);
        step();
        sample();
        chk("nofwd_ack", 8'(bus.host_ack), 8'd1);
        chk("nofwd_rdata_ack", 8'(bus.host_rdata), 8'h1);
        bus.host_req  = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 4'h2;
        bus.cpu_wdata = 4'h9;
        #1;
        chk("nofwd_cpu_wren", 8'(bus.mem_wren), 8'd1);
        step();
        bus.cpu_we = 1'b0;
        sample();
        chk("nofwd_rdata_after", 8'(bus.host_rdata), 8'h1);
        chk("nofwd_cpu_read", 8'(bus.cpu_rdata), 8'h9);
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = 4'h0;

        // Reset asserted during GNT
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 4'h3;
        step();
        sample();
        chk("rst_gnt_addr", 8'(bus.mem_addr), 8'h3);
        reset = 1'b1;
        #1;
        chk("rst_mid_ack", 8'(bus.host_ack), 8'd0);
        chk("rst_mid_rdata", 8'(bus.host_rdata), 8'd0);
        chk("rst_mid_idle_mux", 8'(bus.mem_addr), 8'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            sample();
            chk("rst_hold_ack", 8'(bus.host_ack), 8'd0);
        end
        bus.host_req = 1'b0;
        reset        = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            sample();
            chk("rst_after_ack", 8'(bus.host_ack), 8'd0);
            chk("rst_after_rdata", 8'(bus.host_rdata), 8'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
